simon_64128: RTL and testbench
==============================

Name: simon_64128

Overview:
- Iterative SIMON 64/128 block cipher core. Word size 32 bits, 4 key words, 44 rounds.
- Expands a 128-bit key into a stored round-key file, then encrypts or decrypts 64-bit blocks at one round per clock.
- Sits between a host-side load/read handshake and the rest of the datapath.
- Uses a level-based request/acknowledge protocol for key load, data load and result read.

Parameters:
- N, 32: word width in bits.
- M, 4: number of key words.
- T, 44: number of rounds (and round keys).
- Co, 6: round/key counter width; must satisfy 2^Co > T.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- newData  input  1  level request: a block is present on inData.
- newKey  input  1  level request: a key is present on key.
- enc_dec  input  1  1 = encrypt, 0 = decrypt; sampled when a block is loaded.
- readData  input  1  host has taken outData.
- inData  input  [1:0][N-1:0]  block; [1] = x (upper word), [0] = y.
- key  input  [M-1:0][N-1:0]  key; key[0] = k0 (least significant word).
- loadData  output  1  one-cycle pulse: block latched.
- loadKey  output  1  one-cycle pulse: key latched.
- doneData  output  1  level: result valid on outData.
- doneKey  output  1  level: round-key schedule complete and valid.
- outData  output  [1:0][N-1:0]  result; same word order as inData.
- mode  output  4  current state code.

Behaviour:
- Reset: state IDLE, mode=0, all outputs 0, counters 0, doneKey cleared. The key must be reloaded after any reset, including a reset mid-operation, which aborts it.
- States and mode codes: IDLE=0, KEYEXP=1, READY=2, ROUNDS=3, DONE=4.
- Key capture:
  - In IDLE or READY with newKey=1: write key[0..3] into rk[0..3].
  - Pulse loadKey, clear doneKey, set cnt=4, go to KEYEXP.
  - newKey has priority over newData in the same cycle.
- KEYEXP, one round key per cycle for cnt = 4..43:
  - tmp = ROR3(rk[cnt-1]) ^ rk[cnt-3].
  - tmp ^= ROR1(tmp).
  - rk[cnt] = ~rk[cnt-4] ^ tmp ^ z3[cnt-4] ^ 3.
  - z3 = 11011011101011000110010111100000010010001010011100110100001111, bit index 0 leftmost, period 62.
  - After writing rk[43]: doneKey=1, go to READY. Total 40 cycles.
- Data capture:
  - In READY with newData=1 and newKey=0: latch x=inData[1], y=inData[0], and enc_dec.
  - Pulse loadData, set cnt=0, go to ROUNDS.
  - newData is ignored in IDLE, KEYEXP, ROUNDS and DONE.
- ROUNDS, one round per cycle, f(a) = (ROL1 a & ROL8 a) ^ ROL2 a:
  - Encrypt with k = rk[cnt]: x' = y ^ f(x) ^ k, y' = x.
  - Decrypt with k = rk[T-1-cnt]: y' = x ^ f(y) ^ k, x' = y.
  - After cnt = T-1 (44 cycles after loadData): go to DONE, doneData=1, outData = {x, y}.
- DONE:
  - outData holds stable.
  - On readData=1: doneData=0, go to READY.
  - A newKey arriving in DONE is held off until READY.
- doneKey stays 1 across any number of blocks until a new key is captured or reset.
- Requests are level-sensitive; the host must drop newData/newKey within a few cycles after the load pulse. A still-high request in READY starts a new operation.

Optional Feature:
- Macro SIMON_ZEROIZE_EN.
- Defined: outData is forced to 0 whenever doneData=0, so intermediate round state is never visible.
- Undefined: outData continuously shows the working {x, y} register, including during rounds.

Test Plan:
- Key 1b1a1918_13121110_0b0a0908_03020100 with newKey=1 -> loadKey pulse; doneKey rises 40 cycles later; mode 1 then 2.
- Encrypt 656b696c_20646e75 (enc_dec=1) -> loadData pulse; doneData 44 cycles later; outData = 44c8fc20_b9dfa07a.
- Decrypt 44c8fc20_b9dfa07a (enc_dec=0, same key) -> outData = 656b696c_20646e75.
- Stream a8d5f7de_0123fedc, 5bc92d01_4567ba98, f2b48d45_89ab7654, 567f11de_cdef3210 -> encrypt each, reset, rekey, decrypt each -> every plaintext recovered.
- readData held low -> doneData and outData held indefinitely; newData is not accepted until readData=1.
- rst asserted mid-ROUNDS -> all outputs 0 immediately, mode=0; newData ignored until a new key has been expanded.

Source files
------------

// File: rtl/simon_64128.sv
// Iterative SIMON 64/128 core: stored key schedule, one round per clock.
// Define SIMON_ZEROIZE_EN to blank outData until a result is valid.
module simon_64128 #(
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int T  = 44,
  parameter int Co = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [1:0][N-1:0]   inData,
  input  logic [M-1:0][N-1:0] key,
  output logic                loadData,
  output logic                loadKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    KEYEXP = 4'd1,
    READY  = 4'd2,
    ROUNDS = 4'd3,
    DONE   = 4'd4
  } state_t;

  // z3 sequence; leftmost character sits in bit 61
  localparam logic [61:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
    return (a >> s) | (a << (N - s));
  endfunction

  state_t          r_state, w_next;
  logic [Co-1:0]   r_cnt;
  logic [N-1:0]    r_x, r_y;
  logic            r_enc;
  logic            r_load_data, r_load_key;
  logic            r_done_data, r_done_key;
  logic [N-1:0]    r_rk [T];

  logic            w_key_cap, w_data_cap, w_last;
  logic [Co-1:0]   w_zidx, w_dec_idx;
  logic            w_z;
  logic [N-1:0]    w_t, w_t2, w_new_rk;
  logic [N-1:0]    w_fin, w_f, w_k;

  assign w_last    = (r_cnt == Co'(T - 1));
  assign w_zidx    = Co'(61) - (r_cnt - Co'(4));
  assign w_z       = Z3[w_zidx];
  assign w_t       = ror(r_rk[r_cnt - Co'(1)], 3) ^ r_rk[r_cnt - Co'(3)];
  assign w_t2      = w_t ^ ror(w_t, 1);
  assign w_new_rk  = ~r_rk[r_cnt - Co'(4)] ^ w_t2
                   ^ {{(N-1){1'b0}}, w_z} ^ N'(3);

  assign w_dec_idx = Co'(T - 1) - r_cnt;
  assign w_fin     = r_enc ? r_x : r_y;
  assign w_f       = (rol(w_fin, 1) & rol(w_fin, 8)) ^ rol(w_fin, 2);
  assign w_k       = r_enc ? r_rk[r_cnt] : r_rk[w_dec_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_key_cap  = 1'b0;
    w_data_cap = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (newKey) begin
          w_key_cap = 1'b1;
          w_next    = KEYEXP;
        end
      end
      KEYEXP: if (w_last) w_next = READY;
      READY: begin
        if (newKey) begin
          w_key_cap = 1'b1;
          w_next    = KEYEXP;
        end else if (newData) begin
          w_data_cap = 1'b1;
          w_next     = ROUNDS;
        end
      end
      ROUNDS: if (w_last) w_next = DONE;
      DONE:   if (readData) w_next = READY;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_enc       <= 1'b0;
      r_load_data <= 1'b0;
      r_load_key  <= 1'b0;
      r_done_data <= 1'b0;
      r_done_key  <= 1'b0;
    end else begin
      r_load_key  <= w_key_cap;
      r_load_data <= w_data_cap;
      if (w_key_cap) begin
        r_cnt      <= Co'(4);
        r_done_key <= 1'b0;
      end else if (w_data_cap) begin
        r_x   <= inData[1];
        r_y   <= inData[0];
        r_enc <= enc_dec;
        r_cnt <= '0;
      end else begin
        case (r_state)
          KEYEXP: begin
            r_cnt <= r_cnt + Co'(1);
            if (w_last) r_done_key <= 1'b1;
          end
          ROUNDS: begin
            r_cnt <= r_cnt + Co'(1);
            if (r_enc) begin
              r_x <= r_y ^ w_f ^ w_k;
              r_y <= r_x;
            end else begin
              r_y <= r_x ^ w_f ^ w_k;
              r_x <= r_y;
            end
            if (w_last) r_done_data <= 1'b1;
          end
          DONE: if (readData) r_done_data <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Round-key storage needs no reset: doneKey gates its use
  always_ff @(posedge clk) begin
    if (w_key_cap) begin
      for (int i = 0; i < M; i++) r_rk[i] <= key[i];
    end else if (r_state == KEYEXP) begin
      r_rk[r_cnt] <= w_new_rk;
    end
  end

  assign loadData = r_load_data;
  assign loadKey  = r_load_key;
  assign doneData = r_done_data;
  assign doneKey  = r_done_key;
  assign mode     = r_state;

`ifdef SIMON_ZEROIZE_EN
  assign outData = r_done_data ? {r_x, r_y} : '0;
`else
  assign outData = {r_x, r_y};
`endif

endmodule

// File: tb/tb_simon_64128.sv
// Directed bench for simon_64128 with a reference cipher model
// and a scoreboard queue of expected results.
module tb_simon_64128;

  logic              clk = 1'b0;
  logic              rst;
  logic              newData, newKey, enc_dec, readData;
  logic [1:0][31:0]  inData;
  logic [3:0][31:0]  key;
  logic              loadData, loadKey, doneData, doneKey;
  logic [1:0][31:0]  outData;
  logic [3:0]        mode;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  simon_64128 dut (
    .clk(clk), .rst(rst), .newData(newData), .newKey(newKey),
    .enc_dec(enc_dec), .readData(readData), .inData(inData),
    .key(key), .loadData(loadData), .loadKey(loadKey),
    .doneData(doneData), .doneKey(doneKey), .outData(outData),
    .mode(mode)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K0 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [61:0] ZS =
    62'b11011011101011000110010111100000010010001010011100110100001111;

  function automatic logic [31:0] rotr(input logic [31:0] a, input int s);
    return (a >> s) | (a << (32 - s));
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] a, input int s);
    return (a << s) | (a >> (32 - s));
  endfunction

  function automatic logic [63:0] model(input logic [127:0] k128,
                                        input logic [63:0] blk,
                                        input logic enc);
    logic [31:0] k [44];
    logic [31:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = k128[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = rotr(k[i-1], 3) ^ k[i-3];
      t = t ^ rotr(t, 1);
      k[i] = ~k[i-4] ^ t ^ {31'b0, ZS[61-(i-4)]} ^ 32'd3;
    end
    x = blk[63:32];
    y = blk[31:0];
    if (enc) begin
      for (int i = 0; i < 44; i++) begin
        t = x;
        x = y ^ ((rotl(x,1) & rotl(x,8)) ^ rotl(x,2)) ^ k[i];
        y = t;
      end
    end else begin
      for (int i = 43; i >= 0; i--) begin
        t = y;
        y = x ^ ((rotl(y,1) & rotl(y,8)) ^ rotl(y,2)) ^ k[i];
        x = t;
      end
    end
    return {x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    @(negedge clk);
    key = k;
    newKey = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!loadKey && n < 10);
    newKey = 1'b0;
    check("loadKey", loadKey, 1);
    check("mode_keyexp", mode, 1);
    check("doneKey_clr", doneKey, 0);
    n = 0;
    while (!doneKey && n < 100) begin @(negedge clk); n++; end
    check("keyexp_lat", n, 40);
    check("mode_ready", mode, 2);
  endtask

  task automatic start_block(input logic [63:0] pt, input logic e,
                             input logic [63:0] exp);
    int n;
    @(negedge clk);
    inData = pt;
    enc_dec = e;
    newData = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!loadData && n < 10);
    newData = 1'b0;
    check("loadData", loadData, 1);
    check("mode_rounds", mode, 3);
    sb.push_back(exp);
  endtask

  task automatic finish_block(input string tag, input logic do_read);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!doneData && n < 100) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, 44);
    exp = sb.pop_front();
    check(tag, outData, exp);
    check({tag, "_mode"}, mode, 4);
    if (do_read) begin
      readData = 1'b1;
      @(negedge clk);
      readData = 1'b0;
      check({tag, "_rd"}, doneData, 0);
      check({tag, "_rdmode"}, mode, 2);
    end
  endtask

  logic [63:0] pts [4];
  logic [63:0] hold;
  logic        seen;

  initial begin
    pts[0] = 64'ha8d5f7de_0123fedc;
    pts[1] = 64'h5bc92d01_4567ba98;
    pts[2] = 64'hf2b48d45_89ab7654;
    pts[3] = 64'h567f11de_cdef3210;
    rst = 1'b1;
    newData = 0; newKey = 0; enc_dec = 0; readData = 0;
    inData = '0; key = '0;
    #1;
    check("rst_out", outData, 0);
    check("rst_flags", {loadData, loadKey, doneData, doneKey}, 0);
    check("rst_mode", mode, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load_key(K0);
    start_block(64'h656b696c_20646e75, 1'b1, 64'h44c8fc20_b9dfa07a);
    finish_block("enc_kat", 1'b1);
    start_block(64'h44c8fc20_b9dfa07a, 1'b0, 64'h656b696c_20646e75);
    finish_block("dec_kat", 1'b0);

    // Result held while readData stays low; newData refused meanwhile
    hold = outData;
    inData = pts[0];
    newData = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (loadData) seen = 1'b1;
    end
    newData = 1'b0;
    check("hold_done", doneData, 1);
    check("hold_out", outData, hold);
    check("hold_noload", seen, 0);
    check("hold_doneKey", doneKey, 1);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    check("hold_rd", doneData, 0);

    for (int i = 0; i < 4; i++) begin
      start_block(pts[i], 1'b1, model(K0, pts[i], 1'b1));
      finish_block("enc_stream", 1'b1);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_doneKey", doneKey, 0);
    load_key(K0);
    for (int i = 0; i < 4; i++) begin
      start_block(model(K0, pts[i], 1'b1), 1'b0, pts[i]);
      finish_block("dec_stream", 1'b1);
    end

    // Reset in the middle of a block aborts it
    start_block(pts[1], 1'b1, model(K0, pts[1], 1'b1));
    void'(sb.pop_front());
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out", outData, 0);
    check("abort_flags", {loadData, loadKey, doneData, doneKey}, 0);
    check("abort_mode", mode, 0);
    @(negedge clk);
    rst = 1'b0;
    newData = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (loadData || mode != 4'd0) seen = 1'b1;
    end
    newData = 1'b0;
    check("abort_nodata", seen, 0);

    load_key(K0);
    start_block(pts[2], 1'b1, model(K0, pts[2], 1'b1));
    finish_block("post_abort", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
